// File: rtl/decoder_mem_reader.sv
// Avalon-MM read master that drains a word block from the decoder on-chip memory
// and replays it as an Avalon-ST stream, buffered by a small show-ahead FIFO.
module decoder_mem_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 5120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic              clken,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam int SUM_W = ADDR_W + 2;
  localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  ptr;
  logic [LEN_W-1:0]   remaining;
  logic               first_pending;
  logic               err_q;
  logic               inflight, inflight_sop, inflight_eop;

  logic [DATA_W+1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;

  logic [SUM_W-1:0]   end_sum;
  logic               range_ok, len_zero, accept, issue, room, push, pop;
  logic [DATA_W+1:0]  head;

  // Stream handshake: a beat moves when src_valid & src_ready; src_valid never
  // drops and the head entry never changes until that beat has moved.
  assign end_sum  = {2'b00, base_addr} + {1'b0, length};
  assign len_zero = (length == '0);
  assign range_ok = (end_sum <= MEM_LIMIT);
  assign accept   = (state == S_IDLE) && start && !len_zero && range_ok;

  assign room  = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue = (state == S_RUN) && room;
  assign push  = inflight;
  assign pop   = src_valid && src_ready;

  assign head      = fifo_mem[rd_ptr];
  assign src_valid = (fifo_count != '0);
  assign src_data  = src_valid ? head[DATA_W-1:0] : '0;
  assign src_sop   = src_valid && head[DATA_W+1];
  assign src_eop   = src_valid && head[DATA_W];

  assign chipselect = issue;
  assign address    = ptr;
  assign write      = 1'b0;
  assign byteenable = 4'hF;
  assign clken      = 1'b1;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_FIN);
  assign error      = (state == S_FIN) && err_q;
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = accept ? S_RUN : S_FIN;
      S_RUN:   if (issue && remaining == LEN_W'(1)) state_nxt = S_DRAIN;
      // The last beat may leave in the same cycle we decide to finish.
      S_DRAIN: if (!inflight && (fifo_count == '0 ||
                   (fifo_count == CNT_W'(1) && pop))) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      remaining     <= '0;
      first_pending <= 1'b0;
      err_q         <= 1'b0;
      inflight      <= 1'b0;
      inflight_sop  <= 1'b0;
      inflight_eop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == S_IDLE && start) err_q <= !len_zero && !range_ok;
      if (accept) begin
        ptr           <= base_addr;
        remaining     <= length;
        first_pending <= 1'b1;
      end else if (issue) begin
        ptr           <= ptr + ADDR_W'(1);
        remaining     <= remaining - LEN_W'(1);
        first_pending <= 1'b0;
        inflight_sop  <= first_pending;
        inflight_eop  <= (remaining == LEN_W'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO masks every stream output.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_sop, inflight_eop, readdata};
  end

endmodule

// File: tb/tb_decoder_mem_reader.sv
// Directed bench for decoder_mem_reader: memory model, negedge monitor with an
// expected-beat queue, and hand-computed cycle and count expectations.
module tb_decoder_mem_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [13:0] length;
  logic        busy, done, error;
  logic [12:0] address;
  logic        chipselect, write, clken;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [31:0] src_data;
  logic        src_valid, src_ready, src_sop, src_eop;
  logic [1:0]  state_dbg;

  decoder_mem_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .error(error), .address(address),
    .chipselect(chipselect), .write(write), .byteenable(byteenable), .clken(clken),
    .readdata(readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:5119];
  initial begin
    for (int i = 0; i < 5120; i++) mem[i] = 32'hA500_0000 + 32'(i);
    readdata = '0;
  end
  always @(posedge clk) if (chipselect) readdata <= mem[address];

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int beat_cnt, rd_cnt, done_cnt, addr_bad, busy_seen;
  int first_beat_cyc, last_beat_cyc, first_cs_cyc, done_cyc, done_err;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word;

  task automatic clear_stats();
    beat_cnt = 0; rd_cnt = 0; done_cnt = 0; addr_bad = 0; busy_seen = 0;
    first_beat_cyc = -1; last_beat_cyc = -1; first_cs_cyc = -1; done_cyc = -1; done_err = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {src_valid, src_sop, src_eop, src_data}, {1'b1, prev_word});
      prev_stall = src_valid && !src_ready;
      prev_word  = {src_sop, src_eop, src_data};
      if (src_valid && src_ready) begin
        beat_cnt++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        if (exp_q.size() > 0) check("beat", {src_sop, src_eop, src_data}, exp_q.pop_front());
      end
      if (chipselect) begin
        rd_cnt++;
        if (first_cs_cyc < 0) first_cs_cyc = cyc;
        if (address > 13'd5119) addr_bad++;
      end
      if (busy) busy_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = int'(error);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input int base, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == 0), (i == len - 1), 32'hA500_0000 + 32'(base + i)});
  endtask

  task automatic start_block(input int base, input int len, output int s);
    base_addr = 13'(base);
    length    = 14'(len);
    start     = 1'b1;
    s         = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (toggle) src_ready = ~src_ready;
      tick();
      n++;
    end
    check("done_seen", (done_cnt != 0), 1);
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  int s;
  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; src_ready = 1'b0;
    clear_stats();
    tick(); tick();
    check("reset_outputs",
          {busy, done, error, chipselect, address, src_valid, src_sop, src_eop, src_data, state_dbg},
          64'h0);
    check("reset_constants", {write, byteenable, clken}, {1'b0, 4'hF, 1'b1});
    reset = 1'b0;
    tick();

    // Block of 8 from address 0 with the sink always ready.
    clear_stats();
    src_ready = 1'b1;
    load_exp(0, 8);
    start_block(0, 8, s);
    wait_done(40, 1'b0);
    check("t1_first_cs",   first_cs_cyc,   s + 1);
    check("t1_first_beat", first_beat_cyc, s + 3);
    check("t1_last_beat",  last_beat_cyc,  s + 10);
    check("t1_done_cyc",   done_cyc,       s + 11);
    check("t1_error",      done_err,       0);
    check("t1_reads",      rd_cnt,         8);
    check("t1_beats",      beat_cnt,       8);
    check("t1_busy",       busy_seen,      1);
    check("t1_exp_left",   exp_q.size(),   0);

    // Top-of-memory block with a toggling sink.
    clear_stats();
    load_exp(5116, 4);
    start_block(5116, 4, s);
    wait_done(60, 1'b1);
    check("t2_beats",    beat_cnt,     4);
    check("t2_reads",    rd_cnt,       4);
    check("t2_addr_max", addr_bad,     0);
    check("t2_error",    done_err,     0);
    check("t2_exp_left", exp_q.size(), 0);

    // Range overflow by one word.
    clear_stats();
    src_ready = 1'b1;
    start_block(5117, 4, s);
    wait_done(10, 1'b0);
    check("t3_done_cyc", done_cyc,  s + 1);
    check("t3_error",    done_err,  1);
    check("t3_reads",    rd_cnt,    0);
    check("t3_beats",    beat_cnt,  0);
    check("t3_busy",     busy_seen, 0);

    // Zero length.
    clear_stats();
    start_block(10, 0, s);
    wait_done(10, 1'b0);
    check("t4_done_cyc", done_cyc,  s + 1);
    check("t4_error",    done_err,  0);
    check("t4_reads",    rd_cnt,    0);
    check("t4_beats",    beat_cnt,  0);
    check("t4_busy",     busy_seen, 0);

    // Length 20 under a long stall, with a stray start mid-block.
    clear_stats();
    src_ready = 1'b0;
    load_exp(200, 20);
    start_block(200, 20, s);
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin
        base_addr = 13'd0; length = 14'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("t5_stall_reads", rd_cnt,    4);
    check("t5_stall_beats", beat_cnt,  0);
    check("t5_stall_valid", src_valid, 1);
    src_ready = 1'b1;
    wait_done(100, 1'b0);
    check("t5_beats",     beat_cnt,     20);
    check("t5_reads",     rd_cnt,       20);
    check("t5_done_cnt",  done_cnt,     1);
    check("t5_exp_left",  exp_q.size(), 0);
    check("t5_idle",      state_dbg,    0);

    // Reset after the 5th beat of a 16-word block, then a short block.
    clear_stats();
    load_exp(1000, 16);
    start_block(1000, 16, s);
    begin
      int n = 0;
      while (beat_cnt < 5 && n < 50) begin tick(); n++; end
    end
    check("t6_five_beats", beat_cnt, 5);
    reset = 1'b1;
    #1;
    check("t6_reset_outputs",
          {busy, done, error, chipselect, address, src_valid, src_sop, src_eop, src_data, state_dbg},
          64'h0);
    tick(); tick();
    check("t6_no_done", done_cnt, 0);
    reset = 1'b0;
    tick();
    clear_stats();
    load_exp(100, 2);
    start_block(100, 2, s);
    wait_done(20, 1'b0);
    check("t6_beats",     beat_cnt,     2);
    check("t6_done_cyc",  done_cyc,     s + 5);
    check("t6_exp_left",  exp_q.size(), 0);
    check("t6_error",     done_err,     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
